// File: rtl/anthem_seq_ctrl_pkg.sv
// Shared constants for the anthem sequencer: state encoding, message
// length, idle byte and the message bytes themselves.
package anthem_pkg;

    localparam int MSG_LEN = 13;

    localparam logic [7:0] IDLE_CHAR = 8'h00;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        PRESENT = ST_PRESENT,
        HOLD    = ST_HOLD,
        DONE    = ST_DONE
    } state_e;

    // "Soy de Zacapa", byte 0 in the least significant position.
    localparam logic [8*MSG_LEN-1:0] MSG_BYTES = {
        8'h61, 8'h70, 8'h61, 8'h63, 8'h61, 8'h5A, 8'h20,
        8'h65, 8'h64, 8'h20, 8'h79, 8'h6F, 8'h53
    };

endpackage

// File: rtl/anthem_seq_ctrl_if.sv
// Character handshake bundle between the sequencer and the output register.
interface anthem_char_if;

    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ready;

    modport master (output char_out, output char_valid, input char_ready);
    modport slave  (input char_out, input char_valid, output char_ready);

endinterface

// File: rtl/anthem_seq_ctrl_msg_rom.sv
// Combinational message lookup: index to byte, out-of-range gives IDLE_CHAR.
module anthem_msg_rom
    import anthem_pkg::*;
(
    input  logic [7:0] addr_i,
    output logic [7:0] data_o
);

    // Select the addressed message byte; unmatched addresses stay idle.
    always_comb begin
        data_o = IDLE_CHAR;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (addr_i == 8'(i)) begin
                data_o = MSG_BYTES[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/anthem_seq_ctrl.sv
// Anthem sequencer: walks the message ROM, offers each byte on a
// valid/ready handshake, then holds it for a rate-selected interval.
module anthem_seq_ctrl
    import anthem_pkg::*;
#(
    parameter int BASE_DIV   = 1024,
    parameter int PRESCALE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    input  logic [1:0]          rate_sel,
    anthem_char_if.master       ch,
    output logic [7:0]          index,
    output logic                busy,
    output logic                done
);

    localparam logic [PRESCALE_W-1:0] BASE_W = PRESCALE_W'(BASE_DIV);
    localparam logic [PRESCALE_W-1:0] ONE_W  = PRESCALE_W'(1);

    state_e                  state_q;
    logic [7:0]              index_q;
    logic [7:0]              char_q;
    logic                    valid_q;
    logic [1:0]              rate_q;
    logic [PRESCALE_W-1:0]   presc_q;

    logic [7:0]              rom_addr_d;
    logic [7:0]              rom_data;
    logic [PRESCALE_W-1:0]   hold_last;
    logic                    last_idx;
    logic                    hold_end;

    // Terminal prescaler count for the latched rate; modulo wrap is intended
    // when BASE_DIV << 3 equals 2^PRESCALE_W.
    assign hold_last = (BASE_W << rate_q) - ONE_W;
    assign hold_end  = (presc_q == hold_last);
    assign last_idx  = (index_q == 8'(MSG_LEN - 1));

    // Address of the byte loaded at the next load event: the following
    // index while advancing in HOLD, otherwise byte 0 (start or loop wrap).
    always_comb begin
        rom_addr_d = 8'd0;
        if (state_q == HOLD && !last_idx) begin
            rom_addr_d = index_q + 8'd1;
        end
    end

    anthem_msg_rom u_rom (
        .addr_i (rom_addr_d),
        .data_o (rom_data)
    );

    // Playback FSM with prescaler, index counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            index_q <= 8'd0;
            char_q  <= IDLE_CHAR;
            valid_q <= 1'b0;
            rate_q  <= 2'd0;
            presc_q <= '0;
        end else if (ena) begin
            if (stop) begin
                state_q <= IDLE;
                index_q <= 8'd0;
                char_q  <= IDLE_CHAR;
                valid_q <= 1'b0;
                presc_q <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            state_q <= PRESENT;
                            index_q <= 8'd0;
                            char_q  <= rom_data;
                            valid_q <= 1'b1;
                            rate_q  <= rate_sel;
                        end
                    end
                    PRESENT: begin
                        if (valid_q && ch.char_ready) begin
                            state_q <= HOLD;
                            valid_q <= 1'b0;
                            presc_q <= '0;
                        end
                    end
                    HOLD: begin
                        if (hold_end) begin
                            if (!last_idx) begin
                                state_q <= PRESENT;
                                index_q <= index_q + 8'd1;
                                char_q  <= rom_data;
                                valid_q <= 1'b1;
                            end else if (loop_en) begin
                                state_q <= PRESENT;
                                index_q <= 8'd0;
                                char_q  <= rom_data;
                                valid_q <= 1'b1;
                            end else begin
                                state_q <= DONE;
                            end
                        end else begin
                            presc_q <= presc_q + ONE_W;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ch.char_out   = char_q;
    assign ch.char_valid = valid_q;
    assign index         = index_q;
    assign busy          = (state_q == PRESENT) || (state_q == HOLD);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_anthem_seq_ctrl.sv
// Directed bench for anthem_seq_ctrl with BASE_DIV = 4.
module tb_anthem_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [1:0] rate_sel = 2'd0;
    logic [7:0] index;
    logic       busy;
    logic       done;

    anthem_char_if cif ();

    anthem_seq_ctrl #(.BASE_DIV(4), .PRESCALE_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .rate_sel (rate_sel),
        .ch       (cif),
        .index    (index),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] exp_msg [13];

    typedef struct {
        logic       start;
        logic       stop;
        logic       loop_en;
        logic [1:0] rate;
        logic       ready;
        logic       ena;
        logic       exp_valid;
        logic [7:0] exp_char;
        logic [7:0] exp_idx;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; rate_sel = 2'd0;
        ena = 1'b1; cif.char_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (cif.char_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int prev;
        int t0;
        int bad;

        exp_msg = '{8'h53, 8'h6F, 8'h79, 8'h20, 8'h64, 8'h65, 8'h20,
                    8'h5A, 8'h61, 8'h63, 8'h61, 8'h70, 8'h61};

        //            st sp lp rate rdy ena  vld char   idx  busy done
        vecs[0]  = '{0, 0, 0, 2'd0, 0, 1,   0, 8'h00, 8'd0, 0, 0};
        vecs[1]  = '{1, 0, 0, 2'd0, 0, 1,   1, 8'h53, 8'd0, 1, 0};
        vecs[2]  = '{1, 0, 0, 2'd3, 0, 1,   1, 8'h53, 8'd0, 1, 0};
        vecs[3]  = '{0, 0, 0, 2'd3, 1, 1,   0, 8'h53, 8'd0, 1, 0};
        vecs[4]  = '{0, 0, 0, 2'd0, 1, 1,   0, 8'h53, 8'd0, 1, 0};
        vecs[5]  = '{0, 0, 0, 2'd0, 1, 1,   0, 8'h53, 8'd0, 1, 0};
        vecs[6]  = '{0, 0, 0, 2'd0, 1, 1,   0, 8'h53, 8'd0, 1, 0};
        vecs[7]  = '{0, 0, 0, 2'd0, 0, 1,   1, 8'h6F, 8'd1, 1, 0};
        vecs[8]  = '{0, 0, 0, 2'd0, 1, 0,   1, 8'h6F, 8'd1, 1, 0};
        vecs[9]  = '{0, 0, 0, 2'd0, 1, 1,   0, 8'h6F, 8'd1, 1, 0};
        vecs[10] = '{1, 1, 0, 2'd0, 0, 1,   0, 8'h00, 8'd0, 0, 0};
        vecs[11] = '{1, 0, 0, 2'd0, 1, 0,   0, 8'h00, 8'd0, 0, 0};

        cif.char_ready = 1'b0;
        do_reset();

        // Reset values.
        chk("reset_char",  32'(cif.char_out), 32'h00);
        chk("reset_valid", 32'(cif.char_valid), 32'h0);
        chk("reset_index", 32'(index), 32'h0);
        chk("reset_busy",  32'(busy), 32'h0);
        chk("reset_done",  32'(done), 32'h0);

        // Table-driven cycle vectors: inputs before an edge, outputs after it.
        for (int i = 0; i < 12; i++) begin
            start = vecs[i].start; stop = vecs[i].stop; loop_en = vecs[i].loop_en;
            rate_sel = vecs[i].rate; cif.char_ready = vecs[i].ready; ena = vecs[i].ena;
            tick();
            chk($sformatf("vec%0d {vld,char,idx,busy,done}", i),
                32'({cif.char_valid, cif.char_out, index, busy, done}),
                32'({vecs[i].exp_valid, vecs[i].exp_char, vecs[i].exp_idx,
                     vecs[i].exp_busy, vecs[i].exp_done}));
        end

        // Single-shot playback with ready tied high.
        do_reset();
        pulse_start();
        prev = 0;
        for (int i = 0; i < 13; i++) begin
            wait_valid(ok);
            chk($sformatf("play_seen%0d", i), 32'(ok), 32'h1);
            chk($sformatf("play_char%0d", i), 32'(cif.char_out), 32'(exp_msg[i]));
            chk($sformatf("play_idx%0d", i), 32'(index), 32'(i));
            if (i > 0) chk($sformatf("play_period%0d", i), 32'(cyc - prev), 32'd5);
            prev = cyc;
            tick();
        end
        for (int k = 0; k < 20 && done !== 1'b1; k++) tick();
        chk("done_delay", 32'(cyc - prev), 32'd5);
        chk("done_flag",  32'(done), 32'h1);
        chk("done_char",  32'(cif.char_out), 32'h61);
        chk("done_valid", 32'(cif.char_valid), 32'h0);
        chk("done_busy",  32'(busy), 32'h0);

        // Loop playback wraps to byte 0 with no gap.
        do_reset();
        loop_en = 1'b1;
        pulse_start();
        prev = 0;
        for (int i = 0; i < 14; i++) begin
            wait_valid(ok);
            chk($sformatf("loop_seen%0d", i), 32'(ok), 32'h1);
            chk($sformatf("loop_char%0d", i), 32'(cif.char_out), 32'(exp_msg[i % 13]));
            chk($sformatf("loop_idx%0d", i), 32'(index), 32'(i % 13));
            if (i > 0) chk($sformatf("loop_period%0d", i), 32'(cyc - prev), 32'd5);
            prev = cyc;
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Rate latched at start; later rate_sel changes have no effect.
        do_reset();
        rate_sel = 2'd3;
        pulse_start();
        rate_sel = 2'd0;
        wait_valid(ok);
        t0 = cyc;
        tick();
        wait_valid(ok);
        chk("rate3_seen",   32'(ok), 32'h1);
        chk("rate3_period", 32'(cyc - t0), 32'd33);
        chk("rate3_char",   32'(cif.char_out), 32'h6F);

        // stop and start together at index 5: stop wins.
        do_reset();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            wait_valid(ok);
            if (i < 5) tick();
        end
        chk("idx5_reached", 32'(index), 32'd5);
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("stopstart_char",  32'(cif.char_out), 32'h00);
        chk("stopstart_idx",   32'(index), 32'h0);
        chk("stopstart_busy",  32'(busy), 32'h0);
        chk("stopstart_valid", 32'(cif.char_valid), 32'h0);
        chk("stopstart_done",  32'(done), 32'h0);

        // ena low for 20 cycles in HOLD freezes everything.
        do_reset();
        pulse_start();
        wait_valid(ok);
        tick();
        tick();
        ena = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (cif.char_valid !== 1'b0 || cif.char_out !== 8'h53 ||
                busy !== 1'b1 || index !== 8'd0) bad++;
        end
        chk("freeze_bad_cycles", 32'(bad), 32'd0);
        ena = 1'b1;
        tick();
        tick();
        chk("resume_still_hold", 32'(cif.char_valid), 32'h0);
        tick();
        chk("resume_valid", 32'(cif.char_valid), 32'h1);
        chk("resume_char",  32'(cif.char_out), 32'h6F);
        chk("resume_idx",   32'(index), 32'h1);

        // Asynchronous reset mid-HOLD.
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_char",  32'(cif.char_out), 32'h00);
        chk("areset_valid", 32'(cif.char_valid), 32'h0);
        chk("areset_idx",   32'(index), 32'h0);
        chk("areset_busy",  32'(busy), 32'h0);
        chk("areset_done",  32'(done), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
